// File: rtl/dm_responder.sv
// -----------------------------------------------------------------------------
// dm_responder
//
// Slave end of the MEM-stage data-memory interface. Accepts one word-addressed
// read or write at a time, inserts WAIT_CYCLES wait states, then answers with a
// one-cycle ack. Addresses at or above DEPTH are flagged with err and never
// touch the array.
//
// Parameters:
//   ADDR_W      word-address width
//   DEPTH       number of 32-bit words implemented (DEPTH <= 2**ADDR_W)
//   WAIT_CYCLES wait states between acceptance and response (0..15)
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   synchronous active-low reset
//   req    in   request strobe, sampled only while idle
//   we     in   1 = write, 0 = read
//   addr   in   word address
//   wdata  in   write data
//   rdata  out  read data (write-through on writes), held between acks
//   ack    out  one-cycle response strobe
//   busy   out  request in flight, requester must stall
//   err    out  address out of range, valid with ack
// -----------------------------------------------------------------------------
module dm_responder #(
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ack,
  output logic              busy,
  output logic              err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]      CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [31:0]       wdata_q;

  logic [31:0] mem [DEPTH];

  // Commit-edge view of the request. With zero wait states the commit edge is
  // the accepting edge itself, so the live inputs are used instead of the
  // captured copies (which only load on that same edge).
  logic              commit;
  logic [ADDR_W-1:0] c_addr;
  logic              c_we;
  logic [31:0]       c_wdata;
  logic              c_in_range;
  logic [IDX_W-1:0]  c_idx;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    commit  = 1'b0;
    c_addr  = addr_q;
    c_we    = we_q;
    c_wdata = wdata_q;
    if (state == IDLE) begin
      c_addr  = addr;
      c_we    = we;
      c_wdata = wdata;
      commit  = req && (WAIT_CYCLES == 0);
    end else if (state == WAIT) begin
      commit  = (cnt == 4'd0);
    end
    c_in_range = ({1'b0, c_addr} < DEPTH_C);
    c_idx      = c_addr[IDX_W-1:0];
  end

  assign busy = (state != IDLE);
  assign ack  = (state == RESP);

  // Control, captured request and response registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata   <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            addr_q  <= addr;
            we_q    <= we;
            wdata_q <= wdata;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (commit) begin
        if (c_in_range) begin
          err   <= 1'b0;
          rdata <= c_we ? c_wdata : mem[c_idx];
        end else begin
          err   <= 1'b1;
          rdata <= '0;
        end
      end
    end
  end

  // Storage array. Gated by rst_n so a reset on the commit edge drops the write.
  always_ff @(posedge clk) begin
    // NOTE: the memory array is deliberately not reset; only its write is
    // qualified by rst_n.
    if (rst_n && commit && c_we && c_in_range) begin
      mem[c_idx] <= c_wdata;
    end
  end

endmodule
